div_unit: RTL

Multi-cycle 32-bit signed/unsigned divider in the EX stage. It consumes the 8-bit alucontrol produced by the ALU decoder and reacts only to the DIV and DIVU opcodes. It runs a radix-2 restoring division, one quotient bit per cycle. While it runs it stalls the pipeline, and it delivers {remainder, quotient} for the HI/LO write.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit_step.sv | 26 ++
 rtl/div_unit.sv | 121 ++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared opcode constants, state encoding and helpers for the EX-stage divider.
package div_unit_pkg;

    // Decoder opcodes the divider cares about (ADD/NOP listed for completeness)
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;

    // One restoring iteration per quotient bit
    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Two's complement negate when sel is set, pass-through otherwise
    function automatic logic [31:0] cond_neg32(input logic sel, input logic [31:0] x);
        return sel ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Pipeline <-> divider signal bundle; the pipeline is the master.
interface div_unit_if #(parameter int WIDTH = 32);

    logic [7:0]         alucontrol;
    logic               start;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall;

    modport master (
        output alucontrol, start, opdata1, opdata2, annul,
        input  result, ready, stall
    );

    modport slave (
        input  alucontrol, start, opdata1, opdata2, annul,
        output result, ready, stall
    );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration on the packed {remainder, quotient} register.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] remquo_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] remquo_o
);

    logic [WIDTH:0]   partial;
    logic             no_borrow;
    logic [WIDTH-1:0] diff;

    // Shift in the next dividend bit, trial-subtract, keep the difference only if it fits
    always_comb begin
        partial   = remquo_i[2*WIDTH-1:WIDTH-1];
        no_borrow = (partial >= {1'b0, divisor_i});
        diff      = partial[WIDTH-1:0] - divisor_i;
        if (no_borrow) begin
            remquo_o = {diff, remquo_i[WIDTH-2:0], 1'b1};
        end else begin
            remquo_o = {partial[WIDTH-1:0], remquo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider: latches |operands|, runs WIDTH restoring
// steps, applies the sign fix-up and pulses ready with {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    div_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] remquo_q, remquo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               div_req;
    logic               is_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] step_out;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remquo_i (remquo_q),
        .divisor_i(divisor_q),
        .remquo_o (step_out)
    );

    // Next-state logic: request decode, iteration, sign fix-up and abort handling
    always_comb begin
        div_req   = bus.start & ((bus.alucontrol == EXE_DIV_OP) | (bus.alucontrol == EXE_DIVU_OP))
                    & ~bus.annul;
        is_signed = (bus.alucontrol == EXE_DIV_OP);
        abs_a     = cond_neg32(is_signed & bus.opdata1[WIDTH-1], bus.opdata1);
        abs_b     = cond_neg32(is_signed & bus.opdata2[WIDTH-1], bus.opdata2);

        state_d   = state_q;
        remquo_d  = remquo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ready_d   = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (div_req) begin
                    remquo_d  = {{WIDTH{1'b0}}, abs_a};
                    divisor_d = abs_b;
                    neg_quo_d = is_signed & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                    neg_rem_d = is_signed & bus.opdata1[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = (bus.opdata2 == '0) ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: begin
                if (bus.annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            DIV_ON: begin
                if (bus.annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    remquo_d = step_out;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = DIV_END;
                        ready_d  = 1'b1;
                        result_d = {cond_neg32(neg_rem_q, step_out[2*WIDTH-1:WIDTH]),
                                    cond_neg32(neg_quo_q, step_out[WIDTH-1:0])};
                    end
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight division
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            remquo_q  <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            remquo_q  <= remquo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Stall is combinational so the requesting cycle already holds the pipeline
    assign bus.stall  = ((state_q == DIV_IDLE) & div_req) | (state_q == DIV_BYZERO) | (state_q == DIV_ON);
    assign bus.result = result_q;
    assign bus.ready  = ready_q;

endmodule
